// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit and its data RAM.
//   F3_*        RV32I load/store width codes (funct3)
//   lsu_state_t FSM encoding: IDLE -> ACC0 -> (ACC1) -> RESP
//   lane_mask   byte lanes touched by an access, spanning two words:
//               bits [3:0] are the addressed word, bits [7:4] the next word
//   load_extend shifts the addressed lanes down to bit 0, then sign- or
//               zero-extends them according to funct3
// -----------------------------------------------------------------------------
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC0 = 2'd1,
      ST_ACC1 = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_t;

   // Undefined width codes fall back to a full word; they are flagged as
   // errors elsewhere, so the mask never reaches the RAM for them.
   function automatic logic [7:0] lane_mask(input logic [2:0] funct3,
                                            input logic [1:0] offset);
      logic [7:0] base;
      case (funct3)
         F3_B, F3_BU: base = 8'h01;
         F3_H, F3_HU: base = 8'h03;
         default:     base = 8'h0F;
      endcase
      return base << offset;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  offset);
      logic [31:0] s;
      s = word >> {offset, 3'b000};
      case (funct3)
         F3_B:    return {{24{s[7]}}, s[7:0]};
         F3_H:    return {{16{s[15]}}, s[15:0]};
         F3_W:    return s;
         F3_BU:   return {24'h0, s[7:0]};
         F3_HU:   return {16'h0, s[15:0]};
         default: return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_dmem_if.sv
// -----------------------------------------------------------------------------
// lsu_dmem_if
// Request/response bus between the CPU memory stage and lsu_dmem.
//   req_valid/req_ready  request handshake (accepted when both are high)
//   req_we               1 = store, 0 = load
//   req_funct3           RV32I width code
//   req_addr             byte address
//   req_wdata            store data, right-aligned
//   rsp_valid            one-cycle response pulse
//   rsp_rdata            extended load data (0 for stores and errors)
//   rsp_err              error flag, qualified by rsp_valid
// master = CPU side, slave = load/store unit.
// -----------------------------------------------------------------------------
interface lsu_dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_bram.sv
// -----------------------------------------------------------------------------
// dmem_bram
// Single-port synchronous RAM, DEPTH_WORDS x 32, with per-byte write enables.
// One read or one write per cycle; read data appears the cycle after en.
//   clk    clock
//   en     port enable
//   we     byte write enables (all zero = read)
//   addr   word address
//   wdata  write data, lane-aligned
//   rdata  registered read data (holds while no read is issued)
// Contents are not reset.
// -----------------------------------------------------------------------------
module dmem_bram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Write and read share the port: a cycle with any byte enable is a write.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         if (we == 4'b0000) begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/lsu_dmem.sv
// -----------------------------------------------------------------------------
// lsu_dmem
// RV32I load/store unit with private data RAM and one switch/LED register.
// Executes LB/LH/LW/LBU/LHU/SB/SH/SW with byte-lane steering and extension.
//   clk, rst   clock, asynchronous active-high reset
//   bus        lsu_dmem_if.slave request/response bus
//   sw         board switches (read at MMIO_ADDR as {16'b0, sw})
//   led        board LEDs (written by stores to MMIO_ADDR, lanes 0-1)
// Parameters: DEPTH_WORDS (power of two), BASE_ADDR (byte address of word 0),
//             MMIO_ADDR (address of the IO word).
// Build option: define MISALIGN_SPLIT_EN to execute word-crossing accesses as
// two RAM beats (ACC0 low word, ACC1 next word). Without it every access not
// aligned to its size returns an error and ACC1 is never entered.
// -----------------------------------------------------------------------------
module lsu_dmem
   import lsu_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_0000
) (
   input  logic             clk,
   input  logic             rst,
   lsu_dmem_if.slave        bus,
   input  logic [15:0]      sw,
   output logic [15:0]      led
);

   localparam int          ADDR_W    = $clog2(DEPTH_WORDS);
   localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

   lsu_state_t state, state_nxt;

   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [15:0] sw_q;

   logic              accept;
   logic [31:0]       rel;
   logic              in_ram;
   logic              is_mmio;
   logic [ADDR_W-1:0] word_idx;
   logic [7:0]        mask8;
   logic              crosses;
   logic              misaligned;
   logic              f3_bad;
   logic              err;
   logic [31:0]       store_lo;

   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   logic [31:0]       load_src;
   logic [31:0]       load_val;

`ifdef MISALIGN_SPLIT_EN
   logic              past_end;
   logic              split;
   logic [31:0]       low_q;
   logic [31:0]       store_hi;
   logic [31:0]       load_lo;
   logic [31:0]       merged;
`endif

   assign accept = bus.req_valid && bus.req_ready;

   // ---------------------------------------------------------------------
   // Request decode, all from the registered request fields.
   // rel wraps to a large value for addresses below BASE_ADDR, so a single
   // unsigned compare covers both ends of the RAM window.
   // ---------------------------------------------------------------------
   assign rel      = addr_q - BASE_ADDR;
   assign in_ram   = {1'b0, rel} < RAM_BYTES;
   assign is_mmio  = addr_q[31:2] == MMIO_ADDR[31:2];
   assign word_idx = rel[ADDR_W+1:2];
   assign mask8    = lane_mask(f3_q, addr_q[1:0]);
   assign crosses  = |mask8[7:4];

   // Every misaligned word and the halfword at offset 3 cross a word; the
   // halfword at offset 1 stays inside one word but is still misaligned.
   assign misaligned = crosses ||
                       (((f3_q == F3_H) || (f3_q == F3_HU)) && addr_q[0]);

   assign f3_bad = (f3_q == 3'b011) || (f3_q[2:1] == 2'b11) ||
                   (we_q && f3_q[2]);

`ifdef MISALIGN_SPLIT_EN
   assign past_end = crosses && (word_idx == ADDR_W'(DEPTH_WORDS - 1));
   assign err      = f3_bad || (!in_ram && !is_mmio) ||
                     (is_mmio && misaligned) || past_end;
   assign split    = crosses && !err;
   assign store_lo = wdata_q << {addr_q[1:0], 3'b000};
   assign store_hi = 32'(({32'h0, wdata_q} << {addr_q[1:0], 3'b000}) >> 32);
`else
   assign err      = f3_bad || (!in_ram && !is_mmio) || misaligned;
   assign store_lo = wdata_q << {addr_q[1:0], 3'b000};
`endif

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_ACC0;
`ifdef MISALIGN_SPLIT_EN
         ST_ACC0: state_nxt = split ? ST_ACC1 : ST_RESP;
         ST_ACC1: state_nxt = ST_RESP;
`else
         ST_ACC0: state_nxt = ST_RESP;
`endif
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM outputs: handshake, response and RAM port control
   // ---------------------------------------------------------------------
   always_comb begin
      bus.req_ready = (state == ST_IDLE);
      bus.rsp_valid = (state == ST_RESP);
      bus.rsp_err   = 1'b0;
      bus.rsp_rdata = 32'h0;
      ram_en        = 1'b0;
      ram_we        = 4'b0000;
      ram_addr      = word_idx;
      ram_wdata     = store_lo;
      case (state)
         ST_ACC0: begin
            ram_en = in_ram && !err;
            ram_we = we_q ? mask8[3:0] : 4'b0000;
         end
`ifdef MISALIGN_SPLIT_EN
         ST_ACC1: begin
            ram_en    = 1'b1;
            ram_we    = we_q ? mask8[7:4] : 4'b0000;
            ram_addr  = word_idx + ADDR_W'(1);
            ram_wdata = store_hi;
         end
`endif
         ST_RESP: begin
            bus.rsp_err   = err;
            bus.rsp_rdata = (err || we_q) ? 32'h0 : load_val;
         end
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Load data path. In a split load the first beat's word was captured in
   // ACC1 and the RAM output now holds the next word; concatenating them
   // little-endian and shifting by the offset lines the bytes up at bit 0.
   // ---------------------------------------------------------------------
   always_comb begin
      load_src = is_mmio ? {16'h0, sw_q} : ram_rdata;
`ifdef MISALIGN_SPLIT_EN
      load_lo  = split ? low_q : load_src;
      merged   = 32'({ram_rdata, load_lo} >> {addr_q[1:0], 3'b000});
      load_val = load_extend(merged, f3_q, 2'b00);
`else
      load_val = load_extend(load_src, f3_q, addr_q[1:0]);
`endif
   end

   // Request fields are captured once per transaction and held to RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
      end else if (accept) begin
         we_q    <= bus.req_we;
         f3_q    <= bus.req_funct3;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
      end
   end

   // Switches are sampled and LEDs written during ACC0; store lanes above
   // bit 15 have no LED behind them and are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_q <= 16'h0;
         led  <= 16'h0;
      end else if (state == ST_ACC0) begin
         sw_q <= sw;
         if (is_mmio && we_q && !err) begin
            if (mask8[0]) led[7:0]  <= store_lo[7:0];
            if (mask8[1]) led[15:8] <= store_lo[15:8];
         end
      end
   end

`ifdef MISALIGN_SPLIT_EN
   // The first beat's read data is only valid during ACC1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         low_q <= 32'h0;
      end else if (state == ST_ACC1) begin
         low_q <= ram_rdata;
      end
   end
`endif

   dmem_bram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

endmodule
